// File: rtl/save_seq_ctrl_if.sv
// save_seq_ctrl_if: bank-read and DDR write-command channels of the SAVE sequencer.
// The master side (the sequencer) issues bank reads and DDR burst commands; the
// slave side supplies read-ready, command-ready and one response pulse per burst.
interface save_seq_ctrl_if #(
  parameter int BID_W       = 6,
  parameter int ADDR_W      = 12,
  parameter int OFFSET_W    = 4,
  parameter int DDR_ADDR_W  = 32,
  parameter int LINE_SIZE_W = 12
);
  logic                   bank_rd_en;
  logic [BID_W-1:0]       bank_rd_id;
  logic [ADDR_W-1:0]      bank_rd_addr;
  logic [OFFSET_W-1:0]    bank_rd_offset;
  logic                   bank_rd_ready;
  logic                   ddr_cmd_valid;
  logic                   ddr_cmd_ready;
  logic [DDR_ADDR_W-1:0]  ddr_cmd_addr;
  logic [LINE_SIZE_W-1:0] ddr_cmd_len;
  logic                   ddr_wr_resp;

  modport master (
    output bank_rd_en, bank_rd_id, bank_rd_addr, bank_rd_offset,
    output ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len,
    input  bank_rd_ready, ddr_cmd_ready, ddr_wr_resp
  );

  modport slave (
    input  bank_rd_en, bank_rd_id, bank_rd_addr, bank_rd_offset,
    input  ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len,
    output bank_rd_ready, ddr_cmd_ready, ddr_wr_resp
  );
endinterface

// File: rtl/save_seq_ctrl.sv
// save_seq_ctrl: executes one SAVE instruction, moving a strided 2-D bank region to DDR.
// Each line issues one DDR write-burst command followed by its bank word reads; the
// job completes once every burst response has returned.
// Optional: define SAVE_SEQ_PERF_EN to add the perf_cycles / perf_stall counters.
module save_seq_ctrl #(
  parameter int BID_W       = 6,
  parameter int ADDR_W      = 12,
  parameter int DDR_ADDR_W  = 32,
  parameter int LINE_SIZE_W = 12,
  parameter int ALL_SIZE_W  = 16,
  parameter int OFFSET_W    = 4,
  parameter int WORD_BYTES  = 16,
  parameter int OUTST_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   zero_ddr_step,
  input  logic [BID_W-1:0]       reg_wr_bank_id,
  input  logic [ADDR_W-1:0]      reg_wr_bank_addr,
  input  logic [ADDR_W-1:0]      reg_wr_bank_step,
  input  logic [OFFSET_W-1:0]    reg_wr_bank_offset,
  input  logic [LINE_SIZE_W-1:0] reg_wr_line_size,
  input  logic [ALL_SIZE_W-1:0]  reg_wr_total_size,
  input  logic [ALL_SIZE_W-1:0]  reg_wr_ddr_step,
  input  logic [DDR_ADDR_W-1:0]  reg_wr_ddr_addr,
  save_seq_ctrl_if.master        bus,
  output logic                   busy,
  output logic                   wr_done
`ifdef SAVE_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [31:0]            perf_stall
`endif
);
  localparam int BYTE_SH = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {IDLE, CMD, DATA, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BID_W-1:0]       id_q;
  logic [OFFSET_W-1:0]    offset_q;
  logic [LINE_SIZE_W-1:0] line_size_q;
  logic [ALL_SIZE_W-1:0]  remaining_q;
  logic [ADDR_W-1:0]      bank_step_q;
  logic [ADDR_W-1:0]      line_bank_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic [ALL_SIZE_W-1:0]  ddr_step_q;
  logic [DDR_ADDR_W-1:0]  ddr_line_q;
  logic                   zero_step_q;
  logic [LINE_SIZE_W-1:0] rd_cnt_q;
  logic [OUTST_W-1:0]     outst_q;

  logic [LINE_SIZE_W-1:0] cur_len;
  logic [ALL_SIZE_W-1:0]  rem_next;
  logic [DDR_ADDR_W-1:0]  ddr_inc;
  logic                   outst_full, cmd_fire, rd_fire, line_end, resp_take;

  // Current line length, handshake qualifiers and next-line address increments.
  always_comb begin
    cur_len    = (remaining_q < ALL_SIZE_W'(line_size_q)) ? LINE_SIZE_W'(remaining_q)
                                                          : line_size_q;
    outst_full = &outst_q;
    cmd_fire   = (state_q == CMD) && !outst_full && bus.ddr_cmd_ready;
    rd_fire    = (state_q == DATA) && bus.bank_rd_ready;
    line_end   = rd_fire && (rd_cnt_q == cur_len - LINE_SIZE_W'(1));
    resp_take  = bus.ddr_wr_resp && (state_q != IDLE) && (outst_q != '0);
    rem_next   = remaining_q - ALL_SIZE_W'(cur_len);
    ddr_inc    = zero_step_q ? (DDR_ADDR_W'(cur_len) << BYTE_SH) : DDR_ADDR_W'(ddr_step_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    state_d            = state_q;
    bus.bank_rd_en     = 1'b0;
    bus.ddr_cmd_valid  = 1'b0;
    bus.bank_rd_id     = id_q;
    bus.bank_rd_addr   = rd_addr_q;
    bus.bank_rd_offset = offset_q;
    bus.ddr_cmd_addr   = ddr_line_q;
    bus.ddr_cmd_len    = cur_len;
    busy               = (state_q != IDLE);
    wr_done            = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (reg_wr_total_size == '0 || reg_wr_line_size == '0) ? DONE : CMD;
        end
      end
      CMD: begin
        bus.ddr_cmd_valid = !outst_full;
        if (cmd_fire) state_d = DATA;
      end
      DATA: begin
        bus.bank_rd_en = bus.bank_rd_ready;
        if (line_end) state_d = (rem_next != '0) ? CMD : DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0) state_d = DONE;
      end
      DONE: begin
        wr_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job fields latched on start; line cursor advanced as each read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q        <= '0;
      offset_q    <= '0;
      line_size_q <= '0;
      remaining_q <= '0;
      bank_step_q <= '0;
      line_bank_q <= '0;
      rd_addr_q   <= '0;
      ddr_step_q  <= '0;
      ddr_line_q  <= '0;
      zero_step_q <= 1'b0;
      rd_cnt_q    <= '0;
    end else if (state_q == IDLE && start) begin
      id_q        <= reg_wr_bank_id;
      offset_q    <= reg_wr_bank_offset;
      line_size_q <= reg_wr_line_size;
      remaining_q <= reg_wr_total_size;
      bank_step_q <= reg_wr_bank_step;
      line_bank_q <= reg_wr_bank_addr;
      rd_addr_q   <= reg_wr_bank_addr;
      ddr_step_q  <= reg_wr_ddr_step;
      ddr_line_q  <= reg_wr_ddr_addr;
      zero_step_q <= zero_ddr_step;
      rd_cnt_q    <= '0;
    end else if (rd_fire) begin
      if (line_end) begin
        rd_cnt_q    <= '0;
        remaining_q <= rem_next;
        line_bank_q <= line_bank_q + bank_step_q;
        rd_addr_q   <= line_bank_q + bank_step_q;
        ddr_line_q  <= ddr_line_q + ddr_inc;
      end else begin
        rd_cnt_q  <= rd_cnt_q + LINE_SIZE_W'(1);
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end
    end
  end

  // Outstanding burst responses: +1 on accept, -1 on response, never below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      case ({cmd_fire, resp_take})
        2'b10:   outst_q <= outst_q + OUTST_W'(1);
        2'b01:   outst_q <= outst_q - OUTST_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

`ifdef SAVE_SEQ_PERF_EN
  // Saturating busy-cycle and stall counters; busy cycles restart on each job.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (state_q == IDLE && start)  perf_cycles <= '0;
      else if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
      if (!(&perf_stall) && (((state_q == DATA) && !bus.bank_rd_ready) ||
                             (bus.ddr_cmd_valid && !bus.ddr_cmd_ready)))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_save_seq_ctrl.sv
// tb_save_seq_ctrl: scoreboard bench for save_seq_ctrl. Each job's expected DDR
// commands and bank reads are derived from the line rules and queued; a monitor
// compares every DUT read, command accept and completion pulse against the queues.
module tb_save_seq_ctrl;
  localparam int BID_W = 6, ADDR_W = 12, DDR_ADDR_W = 32, LINE_SIZE_W = 12;
  localparam int ALL_SIZE_W = 16, OFFSET_W = 4, WORD_BYTES = 16, OUTST_W = 2;
  localparam int MAX_OUT = (1 << OUTST_W) - 1;

  typedef struct { logic [31:0] addr; logic [11:0] len; } cmd_t;
  typedef struct { logic [5:0] id; logic [11:0] addr; logic [3:0] off; } rd_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, zero_ddr_step = 1'b0;
  logic [BID_W-1:0]       reg_wr_bank_id = '0;
  logic [ADDR_W-1:0]      reg_wr_bank_addr = '0, reg_wr_bank_step = '0;
  logic [OFFSET_W-1:0]    reg_wr_bank_offset = '0;
  logic [LINE_SIZE_W-1:0] reg_wr_line_size = '0;
  logic [ALL_SIZE_W-1:0]  reg_wr_total_size = '0, reg_wr_ddr_step = '0;
  logic [DDR_ADDR_W-1:0]  reg_wr_ddr_addr = '0;
  logic busy, wr_done;
`ifdef SAVE_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  save_seq_ctrl_if #(.BID_W(BID_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
                     .DDR_ADDR_W(DDR_ADDR_W), .LINE_SIZE_W(LINE_SIZE_W)) bus_if ();

  save_seq_ctrl #(.BID_W(BID_W), .ADDR_W(ADDR_W), .DDR_ADDR_W(DDR_ADDR_W),
                  .LINE_SIZE_W(LINE_SIZE_W), .ALL_SIZE_W(ALL_SIZE_W), .OFFSET_W(OFFSET_W),
                  .WORD_BYTES(WORD_BYTES), .OUTST_W(OUTST_W)) dut (
    .clk(clk), .rst(rst), .start(start), .zero_ddr_step(zero_ddr_step),
    .reg_wr_bank_id(reg_wr_bank_id), .reg_wr_bank_addr(reg_wr_bank_addr),
    .reg_wr_bank_step(reg_wr_bank_step), .reg_wr_bank_offset(reg_wr_bank_offset),
    .reg_wr_line_size(reg_wr_line_size), .reg_wr_total_size(reg_wr_total_size),
    .reg_wr_ddr_step(reg_wr_ddr_step), .reg_wr_ddr_addr(reg_wr_ddr_addr),
    .bus(bus_if.master), .busy(busy), .wr_done(wr_done)
`ifdef SAVE_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  int   resp_due[$];
  int   exp_done = 0, out_model = 0, acc_count = 0, stall_count = 0, cyc = 0;
  int   cmd_pct = 100, rd_pct = 100, resp_lo = 3, resp_hi = 3, cmd_hold = 0;
  bit   rd_toggle = 0, hold_resp = 0;
  int   restart_at = 0, release_at = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference model: line k has len=min(line_size, remaining), bank base
  // bank_addr + k*bank_step, DDR base ddr_addr + k*ddr_step or contiguous.
  task automatic model_job(input logic [5:0] id, input logic [11:0] ba, input logic [11:0] bs,
                           input logic [3:0] off, input logic [11:0] ls, input logic [15:0] ts,
                           input logic [15:0] ds, input logic [31:0] da, input bit zero);
    int rem, k, len;
    logic [31:0] ddr;
    rem = int'(ts); k = 0; ddr = da;
    if (ts == 0 || ls == 0) return;
    while (rem > 0) begin
      len = (rem < int'(ls)) ? rem : int'(ls);
      exp_cmd.push_back('{ddr, 12'(len)});
      for (int i = 0; i < len; i++)
        exp_rd.push_back('{id, 12'(int'(ba) + k * int'(bs) + i), off});
      rem -= len;
      k++;
      ddr = zero ? ddr + 32'(len * WORD_BYTES) : da + 32'(k) * 32'(ds);
    end
  endtask

  // Slave-side drivers: ready generation and delayed burst responses.
  initial begin
    bus_if.bank_rd_ready = 1'b0;
    bus_if.ddr_cmd_ready = 1'b0;
    bus_if.ddr_wr_resp   = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cmd_hold > 0) begin
        bus_if.ddr_cmd_ready = 1'b0;
        cmd_hold--;
      end else begin
        bus_if.ddr_cmd_ready = (int'($urandom_range(100, 1)) <= cmd_pct);
      end
      if (rd_toggle) bus_if.bank_rd_ready = !bus_if.bank_rd_ready;
      else           bus_if.bank_rd_ready = (int'($urandom_range(100, 1)) <= rd_pct);
      if (!hold_resp && resp_due.size() > 0 && resp_due[0] <= cyc) begin
        bus_if.ddr_wr_resp = 1'b1;
        void'(resp_due.pop_front());
      end else begin
        bus_if.ddr_wr_resp = 1'b0;
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a read, command or done.
  bit        prev_stall = 0, acc, rsp;
  logic [31:0] prev_addr;
  logic [11:0] prev_len;
  cmd_t      c;
  rd_t       r;
  always @(negedge clk) begin
    if (rst) begin
      exp_cmd.delete(); exp_rd.delete(); resp_due.delete();
      exp_done = 0; out_model = 0; prev_stall = 0;
    end else begin
      if (bus_if.bank_rd_en) begin
        check("rd_needs_ready", bus_if.bank_rd_ready, 1);
        if (exp_rd.size() == 0) begin
          report_fail("rd_extra", $sformatf("unexpected read at 0x%0h", bus_if.bank_rd_addr));
        end else begin
          r = exp_rd.pop_front();
          check("rd_word", {bus_if.bank_rd_id, bus_if.bank_rd_addr, bus_if.bank_rd_offset},
                {r.id, r.addr, r.off});
        end
      end
      if (prev_stall)
        check("cmd_hold", {bus_if.ddr_cmd_valid, bus_if.ddr_cmd_addr, bus_if.ddr_cmd_len},
              {1'b1, prev_addr, prev_len});
      if (bus_if.ddr_cmd_valid) check("cmd_throttle", out_model < MAX_OUT, 1);
      acc = bus_if.ddr_cmd_valid && bus_if.ddr_cmd_ready;
      if (acc) begin
        acc_count++;
        resp_due.push_back(cyc + 1 + int'($urandom_range(resp_hi, resp_lo)));
        if (exp_cmd.size() == 0) begin
          report_fail("cmd_extra", $sformatf("unexpected command 0x%0h", bus_if.ddr_cmd_addr));
        end else begin
          c = exp_cmd.pop_front();
          check("cmd_addr_len", {bus_if.ddr_cmd_addr, bus_if.ddr_cmd_len}, {c.addr, c.len});
        end
      end
      prev_stall = bus_if.ddr_cmd_valid && !bus_if.ddr_cmd_ready;
      if (prev_stall) stall_count++;
      prev_addr = bus_if.ddr_cmd_addr;
      prev_len  = bus_if.ddr_cmd_len;
      rsp = bus_if.ddr_wr_resp && (out_model > 0);
      out_model = out_model + int'(acc) - int'(rsp);
      if (wr_done) begin
        check("done_busy", busy, 1);
        if (exp_done == 0) begin
          report_fail("done_extra", "wr_done without a pending job");
        end else begin
          exp_done--;
          check("done_clean", out_model + exp_cmd.size() + exp_rd.size(), 0);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic scramble_fields();
    zero_ddr_step      = 1'($urandom);
    reg_wr_bank_id     = 6'($urandom);
    reg_wr_bank_addr   = 12'($urandom);
    reg_wr_bank_step   = 12'($urandom);
    reg_wr_bank_offset = 4'($urandom);
    reg_wr_line_size   = 12'($urandom);
    reg_wr_total_size  = 16'($urandom);
    reg_wr_ddr_step    = 16'($urandom);
    reg_wr_ddr_addr    = $urandom;
  endtask

  task automatic drive_start(input logic [5:0] id, input logic [11:0] ba, input logic [11:0] bs,
                             input logic [3:0] off, input logic [11:0] ls, input logic [15:0] ts,
                             input logic [15:0] ds, input logic [31:0] da, input bit zero);
    @(posedge clk); #1;
    reg_wr_bank_id = id; reg_wr_bank_addr = ba; reg_wr_bank_step = bs;
    reg_wr_bank_offset = off; reg_wr_line_size = ls; reg_wr_total_size = ts;
    reg_wr_ddr_step = ds; reg_wr_ddr_addr = da; zero_ddr_step = zero;
    start = 1'b1;
    @(negedge clk);
    check("idle_before_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_fields();
  endtask

  // One job: lat counts negedges after the capture edge until wr_done is seen.
  task automatic run_job(input logic [5:0] id, input logic [11:0] ba, input logic [11:0] bs,
                         input logic [3:0] off, input logic [11:0] ls, input logic [15:0] ts,
                         input logic [15:0] ds, input logic [31:0] da, input bit zero,
                         output int lat, output bit first_valid);
    bit done;
    int acc_base;
    model_job(id, ba, bs, off, ls, ts, ds, da, zero);
    exp_done++;
    acc_base = acc_count;
    drive_start(id, ba, bs, off, ls, ts, ds, da, zero);
    lat = 0; done = 0; first_valid = 0;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        first_valid = bus_if.ddr_cmd_valid;
        check("busy_after_start", busy, 1);
      end
      if (lat == restart_at) begin
        scramble_fields();
        reg_wr_total_size = 16'd3;
        reg_wr_line_size  = 12'd1;
        start = 1'b1;
      end
      if (lat == restart_at + 1) start = 1'b0;
      if (lat == release_at) begin
        check("throttle_accepts", acc_count - acc_base, MAX_OUT);
        hold_resp = 0;
      end
      if (wr_done) done = 1;
    end
    if (!done) begin
      report_fail("job_timeout", $sformatf("no wr_done within %0d cycles", lat));
      hold_resp = 0;
      do_reset();
    end else begin
      @(negedge clk);
      check("done_one_cycle", {wr_done, busy}, 0);
    end
  endtask

  int lat;
  bit fv, seen;
  int stall_base;
  logic [11:0] ls;
  logic [15:0] ts, ds;
  bit zero;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {bus_if.bank_rd_en, bus_if.ddr_cmd_valid, busy, wr_done,
                         bus_if.bank_rd_id, bus_if.bank_rd_addr, bus_if.bank_rd_offset}, 0);
    check("reset_ddr", {bus_if.ddr_cmd_addr, bus_if.ddr_cmd_len}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic strided job: commands (0x1000,4) (0x1100,4) (0x1200,2).
    run_job(6'h05, 12'h010, 12'h020, 4'h3, 12'd4, 16'd10, 16'h0100, 32'h1000, 0, lat, fv);
    check("first_valid_next_cycle", fv, 1);

    // Contiguous DDR: 3 words * 16 bytes -> second command at 0x2030.
    run_job(6'h11, 12'h100, 12'h040, 4'h0, 12'd3, 16'd6, 16'h0000, 32'h2000, 1, lat, fv);

    // Zero-size jobs: wr_done sampled on the 2nd edge counted from start rising.
    run_job(6'h01, 12'h000, 12'h001, 4'h1, 12'd4, 16'd0, 16'h0010, 32'h3000, 0, lat, fv);
    check("zero_total_latency", lat + 1, 2);
    check("zero_total_no_cmd", fv, 0);
    run_job(6'h02, 12'h000, 12'h001, 4'h1, 12'd0, 16'd5, 16'h0010, 32'h3000, 0, lat, fv);
    check("zero_line_latency", lat + 1, 2);

    // Backpressure on both channels.
    cmd_hold = 7; rd_toggle = 1; stall_base = stall_count;
    run_job(6'h22, 12'h200, 12'h010, 4'h7, 12'd4, 16'd8, 16'h0040, 32'h4000, 0, lat, fv);
    check("cmd_stall_seen", (stall_count - stall_base) >= 5, 1);
    rd_toggle = 0;

    // Bank address wrap: reads 0xFFE 0xFFF 0x000 0x001.
    run_job(6'h3F, 12'hFFE, 12'h002, 4'hF, 12'd2, 16'd4, 16'h0020, 32'hFFFF_FFF0, 0, lat, fv);

    // Throttle: with responses withheld only MAX_OUT commands may be accepted.
    hold_resp = 1; release_at = 40;
    run_job(6'h07, 12'h300, 12'h001, 4'h2, 12'd1, 16'd5, 16'h0010, 32'h5000, 0, lat, fv);
    release_at = 0; hold_resp = 0;

    // Reset mid-DATA aborts the job; stray responses while idle are ignored.
    resp_lo = 1; resp_hi = 1;
    model_job(6'h09, 12'h400, 12'h010, 4'h4, 12'd8, 16'd16, 16'h0100, 32'h6000, 0);
    exp_done++;
    drive_start(6'h09, 12'h400, 12'h010, 4'h4, 12'd8, 16'd16, 16'h0100, 32'h6000, 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.bank_rd_en) seen = 1;
    end
    if (!seen) report_fail("reset_mid_setup", "no bank read before reset");
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_ctrl", {bus_if.bank_rd_en, bus_if.ddr_cmd_valid, busy, wr_done,
                             bus_if.bank_rd_id, bus_if.bank_rd_addr, bus_if.bank_rd_offset}, 0);
    check("reset_mid_ddr", {bus_if.ddr_cmd_addr, bus_if.ddr_cmd_len}, 0);
    @(posedge clk); #1 rst = 1'b0;
    resp_due.push_back(cyc);
    resp_due.push_back(cyc + 1);
    repeat (5) @(posedge clk);

    // New job after reset, with an ignored second start while busy.
    resp_lo = 2; resp_hi = 5; restart_at = 4;
    run_job(6'h0A, 12'h500, 12'h008, 4'h5, 12'd3, 16'd9, 16'h0200, 32'h7000, 0, lat, fv);
    restart_at = 0;

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      cmd_pct = int'($urandom_range(100, 40));
      rd_pct  = int'($urandom_range(100, 30));
      resp_lo = 0; resp_hi = int'($urandom_range(8, 0));
      ls   = ($urandom_range(9, 0) == 0) ? 12'd0 : 12'($urandom_range(6, 1));
      ts   = 16'($urandom_range(24, 0));
      zero = 1'($urandom);
      ds   = zero ? 16'd0 : 16'($urandom_range(16'hFFFF, 1));
      run_job(6'($urandom), 12'($urandom), 12'($urandom), 4'($urandom), ls, ts, ds,
              $urandom, zero, lat, fv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end
endmodule
